// File: rtl/sfilter_synth.sv
// sfilter_synth -- all-pole LPC synthesis filter.
//
// Rebuilds y[n] = e[n] - sum_{k=1..ORDER} a_k * y[n-k] from the residue e[n].
// A single time-multiplexed multiplier runs one tap per clock, so each sample
// spends ORDER cycles in MAC before it is presented on the output.
//
// Ports
//   clk, reset       clock; synchronous active-high reset
//   coef_we/addr/data coefficient write port (a_{addr+1}, signed Q4.28),
//                     honoured only while idle and only for addr < ORDER
//   hist_clr         zero the y history (honoured only while idle)
//   in_valid/ready   residue input handshake, residue is signed Q1.15
//   out_valid/ready  sample output handshake, sample is signed Q1.15 saturated
//   busy             high while a sample is in flight (MAC or OUT)
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid and ready are both high. The producer holds its data stable while
// valid is high and ready is low; there is no skid buffer on the input, and
// the output holds sample stable for as long as out_ready stays low.
module sfilter_synth #(
  parameter int ORDER = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               coef_we,
  input  logic [3:0]         coef_addr,
  input  logic signed [31:0] coef_data,
  input  logic               hist_clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [15:0] residue,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] sample,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [31:0] coef [ORDER];
  logic signed [15:0] hist [ORDER];   // hist[0] is y[n-1]
  logic signed [39:0] acc;            // 30 fractional bits
  logic        [3:0]  k;
  logic signed [15:0] sample_q;

  // Datapath for the current tap. Q4.28 x Q1.15 gives 43 fractional bits;
  // rounding half-up and dropping 13 bits lines it up with acc.
  logic signed [47:0] prod;
  logic signed [47:0] prod_rnd;
  logic signed [47:0] acc_ext;
  logic signed [47:0] acc_mac;
  logic signed [47:0] conv;
  logic signed [15:0] sat_val;
  logic               last_tap;
  logic               coef_hit;

  always_comb begin
    prod     = 48'(coef[k]) * 48'(hist[k]);
    prod_rnd = (prod + 48'sd4096) >>> 13;
    acc_ext  = {{8{acc[39]}}, acc};
    acc_mac  = acc_ext - prod_rnd;
    // Output conversion uses the value acc will hold after the final tap,
    // so the saturated sample is ready on the same edge that enters OUT.
    conv     = (acc_mac + 48'sd16384) >>> 15;
    if (conv > 48'sd32767) begin
      sat_val = 16'sh7FFF;
    end else if (conv < -48'sd32768) begin
      sat_val = 16'sh8000;
    end else begin
      sat_val = conv[15:0];
    end
    last_tap = (k == 4'(ORDER - 1));
    coef_hit = (int'(coef_addr) < ORDER);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = MAC;
        end
      end
      MAC: begin
        busy = 1'b1;
        if (last_tap) begin
          state_nxt = OUT;
        end
      end
      OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      k        <= '0;
      sample_q <= '0;
      for (int i = 0; i < ORDER; i++) begin
        coef[i] <= '0;
        hist[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          // Coefficients only change between samples, so a sample in
          // flight always sees one consistent coefficient set.
          if (coef_we && coef_hit) begin
            coef[coef_addr] <= coef_data;
          end
          // The clear lands before the first tap is read, so a sample
          // accepted together with hist_clr sees zero history.
          if (hist_clr) begin
            for (int i = 0; i < ORDER; i++) begin
              hist[i] <= '0;
            end
          end
          if (in_valid) begin
            acc <= {{9{residue[15]}}, residue, 15'd0};
            k   <= '0;
          end
        end
        MAC: begin
          acc <= acc_mac[39:0];
          k   <= k + 4'd1;
          if (last_tap) begin
            sample_q <= sat_val;
          end
        end
        OUT: begin
          // The saturated value is what feeds back into the recursion.
          if (out_ready) begin
            hist[0] <= sample_q;
            for (int i = 1; i < ORDER; i++) begin
              hist[i] <= hist[i-1];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sample = sample_q;

endmodule

// File: tb/tb_sfilter_synth.sv
// Testbench for sfilter_synth: directed test-plan scenarios followed by a
// randomized run, all checked against an arithmetic reference model of the
// synthesis recursion.
module tb_sfilter_synth;

  localparam int ORDER = 10;

  logic        clk;
  logic        reset;
  logic        coef_we;
  logic [3:0]  coef_addr;
  logic [31:0] coef_data;
  logic        hist_clr;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] residue;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sample;
  logic        busy;

  sfilter_synth #(.ORDER(ORDER)) dut (
    .clk       (clk),
    .reset     (reset),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .hist_clr  (hist_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .residue   (residue),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sample    (sample),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Edge numbers of every accepted residue, for initiation-interval checks.
  int acc_q[$];
  always @(posedge clk) begin
    if (!reset && in_valid && in_ready) acc_q.push_back(cyc);
  end

  // ---------------- scoreboard / model ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [31:0] coef_m [ORDER];
  logic [15:0] hist_m [ORDER];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ORDER; i++) begin
      coef_m[i] = '0;
      hist_m[i] = '0;
    end
  endtask

  // y = e - sum a_k*y[n-k] in exact integer arithmetic: Q1.15 residue scaled
  // to 30 fractional bits, each product rounded half-up to 30 fractional bits,
  // result rounded half-up to Q1.15 and saturated.
  function automatic logic [15:0] model_y(input logic [15:0] e);
    longint a, p, r;
    a = longint'($signed(e)) * 32768;
    for (int i = 0; i < ORDER; i++) begin
      p = longint'($signed(coef_m[i])) * longint'($signed(hist_m[i]));
      a = a - ((p + 4096) >>> 13);
    end
    r = (a + 16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic model_push(input logic [15:0] y);
    for (int i = ORDER - 1; i > 0; i--) hist_m[i] = hist_m[i-1];
    hist_m[0] = y;
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_coef(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = addr; coef_data = data;
    if (int'(addr) < ORDER) coef_m[addr] = data;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic clear_coefs();
    for (int i = 0; i < ORDER; i++) write_coef(4'(i), 32'h0);
  endtask

  // Send one residue, optionally stall the output for 'stall' cycles (with an
  // optional a_1 write attempted during the stall) and check the result.
  task automatic send(input logic [15:0] e, input logic clr, input int stall,
                      input logic st_we, input logic [31:0] st_data,
                      output logic [15:0] got);
    int c0;
    int n;
    logic [15:0] ex;
    logic [15:0] s0;
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    residue = e; in_valid = 1'b1; hist_clr = clr; c0 = cyc;
    if (clr) for (int i = 0; i < ORDER; i++) hist_m[i] = '0;
    ex = model_y(e);
    exp_q.push_back(ex);
    @(negedge clk);
    in_valid = 1'b0; hist_clr = 1'b0;
    residue = 16'($urandom);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (out_valid !== 1'b1) begin
      chk("out_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_front());
      got = 'x;
      return;
    end
    chk("latency", 32'(cyc - c0), 32'(ORDER + 1));
    s0 = sample;
    for (int i = 0; i < stall; i++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_sample", {16'd0, sample}, {16'd0, s0});
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      chk("stall_busy", {31'd0, busy}, 32'd1);
      coef_we = st_we && (i == 1); coef_addr = 4'd0; coef_data = st_data;
      @(negedge clk);
    end
    coef_we = 1'b0;
    chk("out_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    got = sample;
    chk("sample", {16'd0, sample}, {16'd0, exp_q.pop_front()});
    model_push(ex);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Stream pass-through samples with in_valid/out_ready held high.
  task automatic stream(input int n_samp);
    int seen;
    int t;
    logic [15:0] ex;
    seen = 0; t = 0;
    acc_q.delete();
    @(negedge clk);
    residue = 16'h4000; in_valid = 1'b1; out_ready = 1'b1;
    while (seen < n_samp && t < 500) begin
      @(negedge clk);
      t++;
      if (out_valid) begin
        ex = model_y(16'h4000);
        chk("stream_sample", {16'd0, sample}, {16'd0, ex});
        model_push(ex);
        seen++;
        if (seen == n_samp) in_valid = 1'b0;
      end
    end
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    chk("stream_count", 32'(seen), 32'(n_samp));
    chk("stream_accepts", 32'(acc_q.size()), 32'(n_samp));
    for (int i = 1; i < acc_q.size(); i++)
      chk("init_interval", 32'(acc_q[i] - acc_q[i-1]), 32'(ORDER + 2));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] y;
    reset = 1'b1; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    hist_clr = 1'b0; in_valid = 1'b0; residue = '0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sample", {16'd0, sample}, 32'd0);

    // Pass-through with zero coefficients.
    send(16'h4000, 1'b0, 0, 1'b0, 32'h0, y);
    chk("pass_4000", {16'd0, y}, 32'h4000);
    stream(3);

    // First-order decay, a_1 = -0.5.
    write_coef(4'd0, 32'hF800_0000);
    send(16'h4000, 1'b1, 0, 1'b0, 32'h0, y); chk("decay0", {16'd0, y}, 32'h4000);
    send(16'h0000, 1'b0, 1, 1'b0, 32'h0, y); chk("decay1", {16'd0, y}, 32'h2000);
    send(16'h0000, 1'b0, 0, 1'b0, 32'h0, y); chk("decay2", {16'd0, y}, 32'h1000);
    send(16'h0000, 1'b0, 2, 1'b0, 32'h0, y); chk("decay3", {16'd0, y}, 32'h0800);

    // Saturation, a_1 = -1.0.
    write_coef(4'd0, 32'hF000_0000);
    send(16'h6000, 1'b1, 0, 1'b0, 32'h0, y); chk("sat0", {16'd0, y}, 32'h6000);
    send(16'h6000, 1'b0, 0, 1'b0, 32'h0, y); chk("sat1", {16'd0, y}, 32'h7FFF);
    send(16'h8000, 1'b0, 0, 1'b0, 32'h0, y); chk("sat2", {16'd0, y}, 32'hFFFF);

    // Backpressure with an a_1 write attempted during the stall.
    write_coef(4'd0, 32'hF800_0000);
    send(16'h4000, 1'b1, 5, 1'b1, 32'h0, y); chk("bp0", {16'd0, y}, 32'h4000);
    send(16'h0000, 1'b0, 0, 1'b0, 32'h0, y); chk("bp_old_coef", {16'd0, y}, 32'h2000);

    // Out-of-range coefficient address is ignored.
    write_coef(4'd15, 32'h1000_0000);
    write_coef(4'(ORDER), 32'h1000_0000);
    send(16'h0000, 1'b0, 0, 1'b0, 32'h0, y); chk("addr_oob", {16'd0, y}, 32'h1000);

    // Reset during MAC tap 3 aborts the sample.
    @(negedge clk);
    residue = 16'h7000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_sample", {16'd0, sample}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    send(16'h1234, 1'b0, 0, 1'b0, 32'h0, y); chk("post_rst_pass", {16'd0, y}, 32'h1234);

    // hist_clr together with in_valid.
    write_coef(4'd0, 32'hF800_0000);
    send(16'h4000, 1'b1, 0, 1'b0, 32'h0, y); chk("clr_prime", {16'd0, y}, 32'h4000);
    send(16'h1000, 1'b1, 0, 1'b0, 32'h0, y); chk("clr_same_cycle", {16'd0, y}, 32'h1000);

    // Randomized run against the model.
    for (int it = 0; it < 30; it++) begin
      if (it % 6 == 0) begin
        for (int i = 0; i < ORDER; i++)
          write_coef(4'(i), 32'($signed($urandom_range(0, 32'h0800_0000)) - 32'sh0400_0000));
      end
      send(16'($urandom), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
           1'b1, 32'($urandom), y);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
